// File: rtl/alu_pipe_unit.sv
// Pipelined integer ALU: the op is computed combinationally on accept, then carried with its
// ROB tag through LATENCY register stages that advance together under writeback backpressure.
module alu_pipe_unit #(
  parameter int XLEN    = 64,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 6,
  parameter int ALU_OPS = 10
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_src1,
  input  logic [XLEN-1:0]    in_src2,
  input  logic [ALU_OPS-1:0] in_alu_type,
  input  logic               in_word,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int SHW    = $clog2(XLEN);
  localparam int OP_ADD = 0;
  localparam int OP_SLT = 1;
  localparam int OP_SLTU = 2;
  localparam int OP_XOR = 3;
  localparam int OP_OR  = 4;
  localparam int OP_AND = 5;
  localparam int OP_SLL = 6;
  localparam int OP_SRL = 7;
  localparam int OP_SRA = 8;
  localparam int OP_SUB = 9;

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] sum_full, diff_full, sll_full, srl_full, sra_full;
  logic [XLEN-1:0] word_add, word_sub, word_sll, word_srl, word_sra;
  logic [XLEN-1:0] result_d;
  logic            slt_bit, sltu_bit;
  logic            advance, accept;

  assign shamt     = in_src2[SHW-1:0];
  assign sum_full  = in_src1 + in_src2;
  assign diff_full = in_src1 - in_src2;
  assign sll_full  = in_src1 << shamt;
  assign srl_full  = in_src1 >> shamt;
  assign sra_full  = $unsigned($signed(in_src1) >>> shamt);
  assign slt_bit   = $signed(in_src1) < $signed(in_src2);
  assign sltu_bit  = in_src1 < in_src2;

  // Word forms exist only on a 64-bit datapath; a 32-bit build maps them onto the full ops.
  generate
    if (XLEN == 64) begin : g_word
      logic [31:0] w_add, w_sub, w_sll, w_srl, w_sra;
      assign w_add    = in_src1[31:0] + in_src2[31:0];
      assign w_sub    = in_src1[31:0] - in_src2[31:0];
      assign w_sll    = in_src1[31:0] << in_src2[4:0];
      assign w_srl    = in_src1[31:0] >> in_src2[4:0];
      assign w_sra    = $unsigned($signed(in_src1[31:0]) >>> in_src2[4:0]);
      assign word_add = {{32{w_add[31]}}, w_add};
      assign word_sub = {{32{w_sub[31]}}, w_sub};
      assign word_sll = {{32{w_sll[31]}}, w_sll};
      assign word_srl = {{32{w_srl[31]}}, w_srl};
      assign word_sra = {{32{w_sra[31]}}, w_sra};
    end else begin : g_no_word
      assign word_add = sum_full;
      assign word_sub = diff_full;
      assign word_sll = sll_full;
      assign word_srl = srl_full;
      assign word_sra = sra_full;
    end
  endgenerate

  // Priority chain resolves multi-hot selects; zero-hot falls through to 0.
  always_comb begin
    result_d = '0;
    if (in_alu_type[OP_SLT])       result_d = {{(XLEN-1){1'b0}}, slt_bit};
    else if (in_alu_type[OP_SLTU]) result_d = {{(XLEN-1){1'b0}}, sltu_bit};
    else if (in_alu_type[OP_SUB])  result_d = in_word ? word_sub : diff_full;
    else if (in_alu_type[OP_ADD])  result_d = in_word ? word_add : sum_full;
    else if (in_alu_type[OP_XOR])  result_d = in_src1 ^ in_src2;
    else if (in_alu_type[OP_OR])   result_d = in_src1 | in_src2;
    else if (in_alu_type[OP_AND])  result_d = in_src1 & in_src2;
    else if (in_alu_type[OP_SLL])  result_d = in_word ? word_sll : sll_full;
    else if (in_alu_type[OP_SRL])  result_d = in_word ? word_srl : srl_full;
    else if (in_alu_type[OP_SRA])  result_d = in_word ? word_sra : sra_full;
  end

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  generate
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
      logic             valid_reg;
      logic [XLEN-1:0]  result_reg;
      logic [TAG_W-1:0] tag_reg;
      logic             valid_next;
      logic [XLEN-1:0]  result_next;
      logic [TAG_W-1:0] tag_next;

      if (gi == 0) begin : g_head
        assign valid_next  = accept;
        assign result_next = accept ? result_d : '0;
        assign tag_next    = accept ? in_tag : '0;
      end else begin : g_body
        assign valid_next  = g_stage[gi-1].valid_reg;
        assign result_next = g_stage[gi-1].result_reg;
        assign tag_next    = g_stage[gi-1].tag_reg;
      end

      always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
          valid_reg  <= 1'b0;
          result_reg <= '0;
          tag_reg    <= '0;
        end else if (advance) begin
          valid_reg  <= valid_next;
          result_reg <= result_next;
          tag_reg    <= tag_next;
        end
      end
    end
  endgenerate

  assign out_valid  = g_stage[LATENCY-1].valid_reg;
  assign out_result = g_stage[LATENCY-1].result_reg;
  assign out_tag    = g_stage[LATENCY-1].tag_reg;

endmodule

// File: tb/tb_alu_pipe_unit.sv
// Bench for alu_pipe_unit: vector table through a tag/latency scoreboard, plus hand-written
// backpressure, flush and mid-stream reset sequences.
module tb_alu_pipe_unit;

  localparam int LAT = 2;
  localparam logic [9:0] OP_ADD  = 10'h001;
  localparam logic [9:0] OP_SLT  = 10'h002;
  localparam logic [9:0] OP_SLTU = 10'h004;
  localparam logic [9:0] OP_XOR  = 10'h008;
  localparam logic [9:0] OP_OR   = 10'h010;
  localparam logic [9:0] OP_AND  = 10'h020;
  localparam logic [9:0] OP_SLL  = 10'h040;
  localparam logic [9:0] OP_SRL  = 10'h080;
  localparam logic [9:0] OP_SRA  = 10'h100;
  localparam logic [9:0] OP_SUB  = 10'h200;

  typedef struct {
    logic [9:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [5:0]  tag;
    int          acc;
    int          stall_at;
  } sb_t;

  logic        clock, reset_n, in_valid, in_ready, in_word, flush, out_valid, out_ready;
  logic [63:0] in_src1, in_src2, out_result;
  logic [9:0]  in_alu_type;
  logic [5:0]  in_tag, out_tag;

  alu_pipe_unit #(.XLEN(64), .LATENCY(LAT), .TAG_W(6), .ALU_OPS(10)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_alu_type(in_alu_type), .in_word(in_word),
    .in_tag(in_tag), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  vec_t        vecs[32];
  sb_t         q[$];
  logic [63:0] cur_exp;
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          stall_cnt = 0;
  int          since_flush = LAT;
  bit          accepted;
  bit          rand_mode = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock of the reference model: predicts out_valid/in_ready, scores the output,
  // then records any acceptance so its result is expected exactly LAT unstalled cycles later.
  task automatic step();
    logic exp_ov, exp_ir;
    @(negedge clock);
    exp_ov = 1'b0;
    if (q.size() > 0) exp_ov = ((cyc - q[0].acc) == LAT + (stall_cnt - q[0].stall_at));
    exp_ir = !exp_ov || out_ready;
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ir});
    if (exp_ov) begin
      chk("out_result", out_result, q[0].res);
      chk("out_tag", {58'd0, out_tag}, {58'd0, q[0].tag});
      if (out_ready) begin
        $display("xact cyc=%0d tag=%0d result=%h", cyc, out_tag, out_result);
        void'(q.pop_front());
      end else begin
        stall_cnt++;
      end
    end else if (since_flush >= LAT) begin
      chk("bubble_result", out_result, 64'd0);
      chk("bubble_tag", {58'd0, out_tag}, 64'd0);
    end
    accepted = 1'b0;
    if (reset_n && !flush && in_valid && exp_ir) begin
      q.push_back('{res: cur_exp, tag: in_tag, acc: cyc, stall_at: stall_cnt});
      accepted = 1'b1;
    end
    if (!reset_n) begin
      q.delete();
      since_flush = LAT;
    end else if (flush) begin
      q.delete();
      since_flush = 0;
    end else if (since_flush < LAT) begin
      since_flush++;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic [9:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [5:0] t, input logic [63:0] e);
    in_valid    = 1'b1;
    in_alu_type = op;
    in_word     = w;
    in_src1     = a;
    in_src2     = b;
    in_tag      = t;
    cur_exp     = e;
  endtask

  task automatic send(input logic [9:0] op, input logic w, input logic [63:0] a,
                      input logic [63:0] b, input logic [5:0] t, input logic [63:0] e);
    drive(op, w, a, b, t, e);
    accepted = 1'b0;
    for (int k = 0; k < 50 && !accepted; k++) begin
      if (rand_mode) out_ready = 1'($urandom_range(0, 1));
      step();
    end
    if (!accepted) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int k = 0; k < 40 && q.size() > 0; k++) begin
      if (rand_mode) out_ready = 1'($urandom_range(0, 1));
      step();
    end
    chk("drain_left", 64'(q.size()), 64'd0);
    rand_mode = 1'b0;
    out_ready = 1'b1;
    step();
  endtask

  initial begin
    vecs[0]  = '{OP_ADD,  1'b0, 64'd5, 64'd7, 64'd12};
    vecs[1]  = '{OP_SUB,  1'b0, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2]  = '{OP_SLT,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1};
    vecs[3]  = '{OP_SLTU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
    vecs[4]  = '{OP_SLT,  1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
    vecs[5]  = '{OP_SLTU, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
    vecs[6]  = '{OP_XOR,  1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0};
    vecs[7]  = '{OP_OR,   1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hFFF0_FFF0_FFF0_FFF0};
    vecs[8]  = '{OP_AND,  1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF000_F000_F000_F000};
    vecs[9]  = '{OP_SLL,  1'b0, 64'd1, 64'd63, 64'h8000_0000_0000_0000};
    vecs[10] = '{OP_SLL,  1'b0, 64'd1, 64'h41, 64'd2};
    vecs[11] = '{OP_SRL,  1'b0, 64'h8000_0000_0000_0000, 64'd63, 64'd1};
    vecs[12] = '{OP_SRA,  1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000};
    vecs[13] = '{OP_SRA,  1'b0, 64'h4000_0000_0000_0000, 64'd4, 64'h0400_0000_0000_0000};
    vecs[14] = '{OP_ADD,  1'b1, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000};
    vecs[15] = '{OP_SUB,  1'b1, 64'h1_0000_0000, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[16] = '{OP_SRA,  1'b1, 64'h8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000};
    vecs[17] = '{OP_SLL,  1'b1, 64'hFFFF_FFFF_0000_0001, 64'h21, 64'd2};
    vecs[18] = '{OP_SRL,  1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0000_0000_0800_0000};
    vecs[19] = '{OP_SLL,  1'b1, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000};
    vecs[20] = '{OP_XOR,  1'b1, 64'hFFFF_FFFF_0000_0000, 64'd0, 64'hFFFF_FFFF_0000_0000};
    vecs[21] = '{OP_SLT,  1'b1, 64'h8000_0000, 64'd1, 64'd0};
    vecs[22] = '{OP_ADD | OP_SUB, 1'b0, 64'd10, 64'd3, 64'd7};
    vecs[23] = '{OP_SLT | OP_ADD, 1'b0, 64'd5, 64'd7, 64'd1};
    vecs[24] = '{OP_XOR | OP_OR | OP_AND, 1'b0, 64'hF0, 64'hFF, 64'h0F};
    vecs[25] = '{OP_SLL | OP_SRL | OP_SRA, 1'b0, 64'h10, 64'd2, 64'h40};
    vecs[26] = '{OP_OR | OP_AND, 1'b0, 64'hF0, 64'h0F, 64'hFF};
    vecs[27] = '{10'h000, 1'b0, 64'd5, 64'd7, 64'd0};
    vecs[28] = '{OP_SLTU | OP_SUB, 1'b0, 64'd1, 64'd2, 64'd1};
    vecs[29] = '{OP_AND | OP_SLL, 1'b0, 64'd3, 64'd1, 64'd1};
    vecs[30] = '{OP_SRL | OP_SRA, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000};
    vecs[31] = '{OP_ADD,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1};

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_alu_type = '0; in_word = 1'b0; in_src1 = '0; in_src2 = '0; in_tag = '0; cur_exp = '0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_result", out_result, 64'd0);
    chk("reset_out_tag", {58'd0, out_tag}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clock);
    #1;

    // Single ADD with idle gaps: result must appear exactly LAT cycles after accept.
    send(OP_ADD, 1'b0, 64'd5, 64'd7, 6'd3, 64'd12);
    drain();

    // Whole table back-to-back, then again under random writeback backpressure.
    for (int i = 0; i < 32; i++)
      send(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b, 6'(i), vecs[i].exp);
    drain();
    rand_mode = 1'b1;
    for (int i = 0; i < 32; i++)
      send(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b, 6'(i + 32), vecs[i].exp);
    drain();

    // Two ops stalled at the output for 3 cycles while a third op waits at the input.
    out_ready = 1'b0;
    send(OP_ADD, 1'b0, 64'd100, 64'd1, 6'd10, 64'd101);
    send(OP_SUB, 1'b0, 64'd50, 64'd8, 6'd11, 64'd42);
    drive(OP_XOR, 1'b0, 64'hAA, 64'h55, 6'd12, 64'hFF);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_hold_result", out_result, 64'd101);
      chk("stall_hold_tag", {58'd0, out_tag}, 64'd10);
    end
    out_ready = 1'b1;
    send(OP_XOR, 1'b0, 64'hAA, 64'h55, 6'd12, 64'hFF);
    drain();

    // Flush during a stall with two ops in flight and an input presented.
    out_ready = 1'b0;
    send(OP_ADD, 1'b0, 64'd1, 64'd1, 6'd20, 64'd2);
    send(OP_ADD, 1'b0, 64'd2, 64'd2, 6'd21, 64'd4);
    drive(OP_ADD, 1'b0, 64'd3, 64'd3, 6'd22, 64'd6);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    send(OP_OR, 1'b0, 64'h0F, 64'h30, 6'd23, 64'h3F);
    drain();

    // Flush while the unit is ready: the same-cycle input must be dropped too.
    send(OP_ADD, 1'b0, 64'd7, 64'd8, 6'd24, 64'd15);
    drive(OP_SUB, 1'b0, 64'd9, 64'd4, 6'd25, 64'd5);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    repeat (4) step();
    send(OP_SUB, 1'b0, 64'd9, 64'd4, 6'd26, 64'd5);
    drain();

    // One-cycle reset mid-stream drops everything in flight.
    send(OP_ADD, 1'b0, 64'd11, 64'd1, 6'd30, 64'd12);
    send(OP_ADD, 1'b0, 64'd12, 64'd1, 6'd31, 64'd13);
    drive(OP_ADD, 1'b0, 64'd13, 64'd1, 6'd32, 64'd14);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1; in_valid = 1'b0;
    chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midreset_out_result", out_result, 64'd0);
    chk("midreset_out_tag", {58'd0, out_tag}, 64'd0);
    repeat (4) step();
    send(OP_SLL, 1'b0, 64'd3, 64'd4, 6'd33, 64'd48);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
